// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu request arbiter.
package fpu_pkg;

    typedef enum logic [1:0] {
        FP_ADD = 2'b00,
        FP_MUL = 2'b01
    } fp_op_t;

    localparam logic [31:0] FP_INVALID_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } fpu_arb_state_t;

    // Any op code with the high bit set is not a supported fpu operation.
    function automatic logic op_is_invalid(logic [1:0] ctrl);
        return ctrl[1];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    int unsigned idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one combinational fpu between NREQ requesters: round-robin grant, operands held
// for LATENCY cycles, registered result returned with the issuing requester id.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned IDW     = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*2-1:0]  req_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [31:0]      rsp_result,
    output logic             rsp_err,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_ctrl,
    input  logic [31:0]      fpu_result,
    output logic             busy
);

    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    fpu_arb_state_t state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic [1:0]     ctrl_q, ctrl_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    result_q, result_d;
    logic           err_q, err_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req      (req_valid),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        err_d     = err_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready = grant;
                    a_d       = req_a[32*int'(grant_id) +: 32];
                    b_d       = req_b[32*int'(grant_id) +: 32];
                    ctrl_d    = req_ctrl[2*int'(grant_id) +: 2];
                    id_d      = grant_id;
                    ptr_d     = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
                    cnt_d     = CW'(LATENCY - 1);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    result_d = fpu_result;
                    err_d    = op_is_invalid(ctrl_q);
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // The fpu sees zeros while idle and keeps the last operands through DONE.
    always_comb begin
        fpu_a      = (state_q == IDLE) ? '0 : a_q;
        fpu_b      = (state_q == IDLE) ? '0 : b_q;
        fpu_ctrl   = (state_q == IDLE) ? '0 : ctrl_q;
        rsp_valid  = (state_q == DONE);
        rsp_id     = id_q;
        rsp_result = result_q;
        rsp_err    = err_q;
        busy       = (state_q != IDLE);
    end

endmodule
